// File: rtl/servo_pwm_multi.sv
// Multi-channel hobby-servo PWM generator: shared 1 us timebase, per-channel clamped
// position->width conversion, double-buffered at frame boundaries. Optional: SERVO_SLEW_EN.
module servo_pwm_multi #(
    parameter int unsigned CLK_HZ    = 50000000,
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned POS_W     = 8,
    parameter int unsigned POS_MAX   = 180,
    parameter int unsigned MIN_US    = 1000,
    parameter int unsigned MAX_US    = 2000,
    parameter int unsigned FRAME_US  = 20000,
    parameter int unsigned RESET_POS = 90,
    parameter int unsigned SLEW_US   = 20,
    localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [CH_W-1:0]        wr_ch,
    input  logic [POS_W-1:0]       wr_pos,
    input  logic [NUM_CH-1:0]      ch_en,
    output logic [NUM_CH-1:0]      pwm_out,
    output logic                   frame_start,
    output logic [NUM_CH*16-1:0]   cur_width
);

    localparam int unsigned DIV     = CLK_HZ / 1000000;
    localparam int unsigned DIV_W   = $clog2(DIV);
    localparam int unsigned US_W    = $clog2(FRAME_US);
    localparam int unsigned RST_P   = (RESET_POS > POS_MAX) ? POS_MAX : RESET_POS;
    localparam logic [15:0] RESET_W = 16'(MIN_US + (RST_P * (MAX_US - MIN_US)) / POS_MAX);

    function automatic logic [15:0] pos_to_width(input logic [POS_W-1:0] pos);
        logic [31:0] p;
        p = 32'(pos);
        if (p > POS_MAX) p = POS_MAX;
        return 16'(MIN_US + (p * (MAX_US - MIN_US)) / POS_MAX);
    endfunction

`ifdef SERVO_SLEW_EN
    localparam logic [15:0] SLEW_W = 16'(SLEW_US);

    function automatic logic [15:0] slew_step(input logic [15:0] cur, input logic [15:0] tgt);
        logic [15:0] res;
        res = tgt;
        if (tgt > cur && (tgt - cur) > SLEW_W)      res = cur + SLEW_W;
        else if (cur > tgt && (cur - tgt) > SLEW_W) res = cur - SLEW_W;
        return res;
    endfunction
`endif

    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [US_W-1:0]   us_cnt_q, us_cnt_d;
    logic              frame_start_q;
    logic [NUM_CH-1:0] pwm_q, pwm_d;
    logic [NUM_CH-1:0] en_q, en_d;
    logic [15:0]       pend_q [NUM_CH];
    logic [15:0]       pend_d [NUM_CH];
    logic [15:0]       act_q  [NUM_CH];
    logic [15:0]       act_d  [NUM_CH];
    logic              us_tick, boundary;
    logic [15:0]       wr_width;

    always_comb begin
        us_tick   = (div_cnt_q == DIV_W'(DIV - 1));
        boundary  = us_tick && (us_cnt_q == US_W'(FRAME_US - 1));
        div_cnt_d = us_tick ? '0 : div_cnt_q + 1'b1;
        us_cnt_d  = us_cnt_q;
        if (us_tick) us_cnt_d = (us_cnt_q == US_W'(FRAME_US - 1)) ? '0 : us_cnt_q + 1'b1;

        wr_width = pos_to_width(wr_pos);
        pend_d   = pend_q;
        act_d    = act_q;
        en_d     = en_q;
        for (int k = 0; k < NUM_CH; k++) begin
            if (wr_en && wr_ch == CH_W'(k)) pend_d[k] = wr_width;
        end

        // Frame boundary: the pending widths and enables become the next frame's settings.
        if (boundary) begin
            en_d = ch_en;
            for (int k = 0; k < NUM_CH; k++) begin
`ifdef SERVO_SLEW_EN
                act_d[k] = slew_step(act_q[k], pend_q[k]);
`else
                act_d[k] = pend_q[k];
`endif
            end
        end

        // Output is computed from next-state values so the rising edge lands with frame_start.
        for (int k = 0; k < NUM_CH; k++) begin
            pwm_d[k] = en_d[k] && (32'(us_cnt_d) < 32'(act_d[k]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q     <= '0;
            us_cnt_q      <= '0;
            frame_start_q <= 1'b0;
            pwm_q         <= '0;
            en_q          <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                pend_q[k] <= RESET_W;
                act_q[k]  <= RESET_W;
            end
        end else begin
            div_cnt_q     <= div_cnt_d;
            us_cnt_q      <= us_cnt_d;
            frame_start_q <= boundary;
            pwm_q         <= pwm_d;
            en_q          <= en_d;
            pend_q        <= pend_d;
            act_q         <= act_d;
        end
    end

    always_comb begin
        cur_width = '0;
        for (int k = 0; k < NUM_CH; k++) cur_width[16*k +: 16] = act_q[k];
    end

    assign pwm_out     = pwm_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Bench for servo_pwm_multi: small timebase, frame-arithmetic reference model, table and
// directed sequences plus randomized writes/enables.
module tb_servo_pwm_multi;

    localparam int unsigned CLK_HZ    = 2000000;
    localparam int unsigned NUM_CH    = 5;
    localparam int unsigned POS_W     = 8;
    localparam int unsigned POS_MAX   = 180;
    localparam int unsigned MIN_US    = 10;
    localparam int unsigned MAX_US    = 100;
    localparam int unsigned FRAME_US  = 120;
    localparam int unsigned RESET_POS = 90;
    localparam int unsigned SLEW_US   = 20;
    localparam int DIV  = 2;
    localparam int FP   = DIV * FRAME_US;
    localparam int CH_W = 3;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  wr_en = 1'b0;
    logic [CH_W-1:0]       wr_ch = '0;
    logic [POS_W-1:0]      wr_pos = '0;
    logic [NUM_CH-1:0]     ch_en = '0;
    logic [NUM_CH-1:0]     pwm_out;
    logic                  frame_start;
    logic [NUM_CH*16-1:0]  cur_width;

    servo_pwm_multi #(
        .CLK_HZ(CLK_HZ), .NUM_CH(NUM_CH), .POS_W(POS_W), .POS_MAX(POS_MAX),
        .MIN_US(MIN_US), .MAX_US(MAX_US), .FRAME_US(FRAME_US),
        .RESET_POS(RESET_POS), .SLEW_US(SLEW_US)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_pos(wr_pos),
        .ch_en(ch_en), .pwm_out(pwm_out), .frame_start(frame_start), .cur_width(cur_width)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: time since reset in clocks; frame index/phase by plain arithmetic.
    bit     model_ok = 1'b0;
    longint t = 0;
    int     pend [NUM_CH];
    int     cw   [NUM_CH];
    bit     cen  [NUM_CH];
    int     trace_err = 0;
    longint first_t = 0;
    logic [NUM_CH-1:0] first_act, first_exp;

    function automatic int tw(input int pos);
        int p;
        p = (pos > int'(POS_MAX)) ? int'(POS_MAX) : pos;
        return int'(MIN_US) + (p * int'(MAX_US - MIN_US)) / int'(POS_MAX);
    endfunction

    always @(posedge clk) begin
        if (rst === 1'b1) begin
            model_ok = 1'b1;
            t = 0;
            for (int k = 0; k < NUM_CH; k++) begin
                pend[k] = tw(RESET_POS);
                cw[k]   = tw(RESET_POS);
                cen[k]  = 1'b0;
            end
        end else if (model_ok) begin
            if (t % FP == FP - 1) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    cw[k]  = pend[k];
                    cen[k] = ch_en[k];
                end
            end
            if (wr_en && wr_ch < NUM_CH) pend[wr_ch] = tw(int'(wr_pos));
            t++;
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            logic [NUM_CH-1:0]    ep;
            logic                 efs;
            logic [NUM_CH*16-1:0] ecw;
            longint               ph;
            ph  = t % FP;
            efs = (ph == 0) && (t >= FP);
            for (int k = 0; k < NUM_CH; k++) begin
                ep[k] = cen[k] && (ph < longint'(cw[k]) * DIV);
                ecw[16*k +: 16] = 16'(cw[k]);
            end
            if (pwm_out !== ep || frame_start !== efs || cur_width !== ecw) begin
                if (trace_err == 0) begin
                    first_t   = t;
                    first_act = pwm_out;
                    first_exp = ep;
                end
                trace_err++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_trace(input string nm);
        checks++;
        if (trace_err != 0) begin
            errors++;
            $display("FAIL %s: %0d cycles differ from model (required 0); first at t=%0d pwm_out=%b expected %b",
                     nm, trace_err, first_t, first_act, first_exp);
        end
        trace_err = 0;
    endtask

    task automatic wait_fs(input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (frame_start !== 1'b1 && n < 2 * FP) begin
            @(negedge clk);
            n++;
        end
        if (frame_start !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s: frame_start not seen within %0d cycles (got 0, expected 1)", nm, 2 * FP);
        end
    endtask

    // Samples one full frame starting at the current (frame_start) negedge.
    task automatic count_high(input int k, output int hi, output int fs);
        hi = 0;
        fs = 0;
        for (int i = 0; i < FP; i++) begin
            if (i > 0) @(negedge clk);
            if (pwm_out[k] === 1'b1) hi++;
            if (frame_start === 1'b1) fs++;
        end
    endtask

    task automatic write1(input int ch, input int pos);
        wr_en  = 1'b1;
        wr_ch  = CH_W'(ch);
        wr_pos = POS_W'(pos);
        step();
        wr_en  = 1'b0;
    endtask

    typedef struct {
        int ch;
        int pos;
        int exp_w;
    } vec_t;

    vec_t tbl [8];
    int   expw [NUM_CH];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected finish)");
        $fatal(1);
    end

    initial begin
        int hi, fs, idx;
        tbl[0] = '{0, 0,   10};
        tbl[1] = '{1, 180, 100};
        tbl[2] = '{2, 45,  32};
        tbl[3] = '{3, 200, 100};
        tbl[4] = '{4, 255, 100};
        tbl[5] = '{0, 91,  55};
        tbl[6] = '{1, 1,   10};
        tbl[7] = '{2, 179, 99};
        for (int k = 0; k < NUM_CH; k++) expw[k] = 55;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset pwm_out", 64'(pwm_out), 0);
        chk("reset frame_start", 64'(frame_start), 0);
        for (int k = 0; k < NUM_CH; k++) chk("reset cur_width", 64'(cur_width[16*k +: 16]), 55);

        step();
        rst   = 1'b0;
        ch_en = 5'h1F;
        wait_fs("first frame");
        chk("aligned rising edge", 64'(pwm_out), 64'h1F);
        count_high(0, hi, fs);
        chk("default high time ch0", 64'(hi), 55 * DIV);
        chk("frame_start per frame", 64'(fs), 1);
        check_trace("default frames");

        for (int i = 0; i < 8; i++) begin
            wait_fs("table frame");
            step();
            write1(tbl[i].ch, tbl[i].pos);
            @(negedge clk);
            chk("table width before boundary", 64'(cur_width[16*tbl[i].ch +: 16]), 64'(expw[tbl[i].ch]));
            wait_fs("table boundary");
            chk("table width after boundary", 64'(cur_width[16*tbl[i].ch +: 16]), 64'(tbl[i].exp_w));
            expw[tbl[i].ch] = tbl[i].exp_w;
        end

        // Mid-pulse double write to ch1: second value wins, current frame untouched.
        wait_fs("mid-pulse frame");
        repeat (10) step();
        wr_en = 1'b1; wr_ch = 3'd1; wr_pos = 8'd100;
        step();
        wr_pos = 8'd20;
        step();
        wr_en = 1'b0;
        @(negedge clk);
        chk("ch1 width unchanged mid-frame", 64'(cur_width[16 +: 16]), 10);
        chk("ch1 pulse still high", 64'(pwm_out[1]), 1);
        wait_fs("mid-pulse boundary");
        chk("ch1 last write wins", 64'(cur_width[16 +: 16]), 20);
        count_high(1, hi, fs);
        chk("ch1 high time", 64'(hi), 20 * DIV);
        expw[1] = 20;

        // Disable ch2 mid-pulse, plus writes to nonexistent channels.
        wait_fs("ch_en frame");
        repeat (20) step();
        ch_en[2] = 1'b0;
        write1(5, 0);
        write1(7, 0);
        @(negedge clk);
        chk("ch2 pulse completes", 64'(pwm_out[2]), 1);
        wait_fs("ch_en boundary");
        for (int k = 0; k < NUM_CH; k++) chk("out-of-range write ignored", 64'(cur_width[16*k +: 16]), 64'(expw[k]));
        count_high(2, hi, fs);
        chk("ch2 disabled frame", 64'(hi), 0);
        step();
        ch_en[2] = 1'b1;
        check_trace("directed");

        // Reset in the middle of a pulse.
        wait_fs("reset frame");
        repeat (40) step();
        rst = 1'b1;
        @(negedge clk);
        chk("ch0 high before reset", 64'(pwm_out[0]), 1);
        @(negedge clk);
        chk("reset drops pwm_out", 64'(pwm_out), 0);
        chk("reset clears frame_start", 64'(frame_start), 0);
        for (int k = 0; k < NUM_CH; k++) chk("reset reloads width", 64'(cur_width[16*k +: 16]), 55);
        step();
        rst = 1'b0;
        for (int k = 0; k < NUM_CH; k++) expw[k] = 55;
        wait_fs("post-reset frame");
        chk("post-reset pulse aligned", 64'(pwm_out), 64'h1F);
        count_high(3, hi, fs);
        chk("post-reset high time ch3", 64'(hi), 55 * DIV);
        check_trace("reset");

        // Randomized writes (including out-of-range channels) and enable toggles.
        for (int c = 0; c < 20 * FP; c++) begin
            step();
            wr_en  = ($urandom_range(0, 29) == 0);
            wr_ch  = CH_W'($urandom_range(0, 7));
            wr_pos = POS_W'($urandom_range(0, 255));
            if ($urandom_range(0, 199) == 0) begin
                idx = int'($urandom_range(0, NUM_CH - 1));
                ch_en[idx] = ~ch_en[idx];
            end
        end
        step();
        wr_en = 1'b0;
        repeat (FP) step();
        check_trace("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
